// File: rtl/alu_iterative.sv
// Execute-stage ALU with a start/done handshake. Logic, arithmetic and
// compare ops finish in one cycle. Shifts run iteratively, SHIFT_STEP bit
// positions per cycle, so only a narrow shifter sits on the critical path.
module alu_iterative #(
   parameter int XLEN       = 32,
   parameter int SHIFT_STEP = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            flush,
   input  logic [3:0]      alu_op,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            busy,
   output logic            done
);

   localparam int SW = $clog2(XLEN);
   localparam logic [SW-1:0] STEP = SW'(SHIFT_STEP);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SLT  = 4'b0101;
   localparam logic [3:0] OP_SLTU = 4'b0110;
   localparam logic [3:0] OP_SLL  = 4'b0111;
   localparam logic [3:0] OP_SRL  = 4'b1000;
   localparam logic [3:0] OP_SRA  = 4'b1001;
   localparam logic [3:0] OP_CLR  = 4'b1010;
   localparam logic [3:0] OP_PASS = 4'b1111;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t          state, state_next;
   logic [XLEN-1:0] acc, acc_next;
   logic [SW-1:0]   rem, rem_next;
   logic [3:0]      op_q, op_next;
   logic [XLEN-1:0] result_next;
   logic            zero_next;
   logic            done_next;

   logic [XLEN-1:0] alu_value;
   logic [XLEN-1:0] shifted;
   logic [SW-1:0]   step;
   logic [SW-1:0]   shamt;
   logic            is_shift;

   assign busy     = (state != IDLE);
   assign shamt    = src_b[SW-1:0];
   assign is_shift = (alu_op == OP_SLL) || (alu_op == OP_SRL) || (alu_op == OP_SRA);

   // Single-cycle result; shift ops return src_a so a zero shamt completes here
   always_comb begin
      alu_value = '0;
      case (alu_op)
         OP_ADD:  alu_value = src_a + src_b;
         OP_SUB:  alu_value = src_a - src_b;
         OP_AND:  alu_value = src_a & src_b;
         OP_OR:   alu_value = src_a | src_b;
         OP_XOR:  alu_value = src_a ^ src_b;
         OP_SLT:  alu_value = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         OP_SLTU: alu_value = {{(XLEN-1){1'b0}}, (src_a < src_b)};
         OP_SLL:  alu_value = src_a;
         OP_SRL:  alu_value = src_a;
         OP_SRA:  alu_value = src_a;
         OP_CLR:  alu_value = src_a & ~src_b;
         OP_PASS: alu_value = src_b;
         default: alu_value = '0;
      endcase
   end

   // One iteration of the shift; the sign bit of acc never changes during sra,
   // so it always equals the sign of the original operand
   always_comb begin
      step    = (rem >= STEP) ? STEP : rem;
      shifted = acc;
      case (op_q)
         OP_SLL:  shifted = acc << step;
         OP_SRL:  shifted = acc >> step;
         default: shifted = XLEN'($signed(acc) >>> step);
      endcase
   end

   // Next-state and datapath updates; flush overrides any start or shift step
   always_comb begin
      state_next  = state;
      acc_next    = acc;
      rem_next    = rem;
      op_next     = op_q;
      result_next = result;
      done_next   = 1'b0;
      if (flush) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (is_shift && (shamt != '0)) begin
                     acc_next   = src_a;
                     rem_next   = shamt;
                     op_next    = alu_op;
                     state_next = SHIFT;
                  end else begin
                     result_next = alu_value;
                     done_next   = 1'b1;
                  end
               end
            end
            SHIFT: begin
               acc_next = shifted;
               rem_next = rem - step;
               if (rem == step) begin
                  result_next = shifted;
                  done_next   = 1'b1;
                  state_next  = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
      zero_next = (result_next == '0);
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc    <= '0;
         rem    <= '0;
         op_q   <= '0;
         result <= '0;
         zero   <= 1'b1;
         done   <= 1'b0;
      end else begin
         acc    <= acc_next;
         rem    <= rem_next;
         op_q   <= op_next;
         result <= result_next;
         zero   <= zero_next;
         done   <= done_next;
      end
   end

endmodule

// File: tb/tb_alu_iterative.sv
// Testbench for alu_iterative: two instances (SHIFT_STEP 1 and 4) share the
// same stimulus and are compared against an arithmetic reference model.
module tb_alu_iterative;

   logic        clk;
   logic        reset;
   logic        start;
   logic        flush;
   logic [3:0]  alu_op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic [31:0] result_1, result_4;
   logic        zero_1, zero_4;
   logic        busy_1, busy_4;
   logic        done_1, done_4;

   int total = 0;
   int bad   = 0;

   logic [31:0] exp_result;
   logic        exp_zero;

   alu_iterative #(.XLEN(32), .SHIFT_STEP(1)) dut_1 (
      .clk(clk), .reset(reset), .start(start), .flush(flush),
      .alu_op(alu_op), .src_a(src_a), .src_b(src_b),
      .result(result_1), .zero(zero_1), .busy(busy_1), .done(done_1)
   );

   alu_iterative #(.XLEN(32), .SHIFT_STEP(4)) dut_4 (
      .clk(clk), .reset(reset), .start(start), .flush(flush),
      .alu_op(alu_op), .src_a(src_a), .src_b(src_b),
      .result(result_4), .zero(zero_4), .busy(busy_4), .done(done_4)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int sh;
      sh = int'(b[4:0]);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd6:    return (a < b) ? 32'd1 : 32'd0;
         4'd7:    return a << sh;
         4'd8:    return a >> sh;
         4'd9:    return 32'($signed(a) >>> sh);
         4'd10:   return a & ~b;
         4'd15:   return b;
         default: return 32'd0;
      endcase
   endfunction

   function automatic int ref_latency(input logic [3:0] op, input logic [31:0] b, input int step);
      int sh;
      sh = int'(b[4:0]);
      if ((op == 4'd7 || op == 4'd8 || op == 4'd9) && sh > 0) return 1 + (sh + step - 1) / step;
      return 1;
   endfunction

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Issue one request and watch both DUTs for 40 cycles. inj_cycle > 0 presents
   // a competing start in that cycle; flush_cycle >= 0 asserts flush in that
   // cycle (0 means together with the start).
   task automatic apply_stimulus(input string name, input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input int inj_cycle, input int flush_cycle);
      int done_cnt1, done_cnt4, lat1, lat4, busy_cnt1, busy_cnt4;
      int exp_lat1, exp_lat4, exp_busy1, exp_busy4, exp_done;
      done_cnt1 = 0; done_cnt4 = 0; lat1 = 0; lat4 = 0; busy_cnt1 = 0; busy_cnt4 = 0;
      @(negedge clk);
      alu_op = op; src_a = a; src_b = b; start = 1'b1;
      flush  = (flush_cycle == 0);
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      alu_op = 4'($urandom); src_a = $urandom; src_b = $urandom;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (done_1) begin done_cnt1++; if (lat1 == 0) lat1 = cyc; end
         if (done_4) begin done_cnt4++; if (lat4 == 0) lat4 = cyc; end
         if (busy_1) busy_cnt1++;
         if (busy_4) busy_cnt4++;
         if (flush_cycle > 0 && cyc == flush_cycle + 1) begin
            check_output({name, "_busy_after_flush_s1"}, 32'(busy_1), 32'd0);
            check_output({name, "_busy_after_flush_s4"}, 32'(busy_4), 32'd0);
         end
         if (cyc == inj_cycle) begin
            start = 1'b1; alu_op = 4'd0; src_a = $urandom; src_b = $urandom;
         end
         if (cyc == flush_cycle) flush = 1'b1;
         @(negedge clk);
         start = 1'b0; flush = 1'b0;
      end
      exp_lat1 = ref_latency(op, b, 1);
      exp_lat4 = ref_latency(op, b, 4);
      if (flush_cycle >= 0) begin
         exp_done  = 0;
         exp_busy1 = (flush_cycle < exp_lat1 - 1) ? flush_cycle : exp_lat1 - 1;
         exp_busy4 = (flush_cycle < exp_lat4 - 1) ? flush_cycle : exp_lat4 - 1;
      end else begin
         exp_done   = 1;
         exp_busy1  = exp_lat1 - 1;
         exp_busy4  = exp_lat4 - 1;
         exp_result = ref_alu(op, a, b);
         exp_zero   = (exp_result == 32'd0);
         check_output({name, "_latency_s1"}, 32'(lat1), 32'(exp_lat1));
         check_output({name, "_latency_s4"}, 32'(lat4), 32'(exp_lat4));
      end
      check_output({name, "_done_count_s1"}, 32'(done_cnt1), 32'(exp_done));
      check_output({name, "_done_count_s4"}, 32'(done_cnt4), 32'(exp_done));
      check_output({name, "_busy_cycles_s1"}, 32'(busy_cnt1), 32'(exp_busy1));
      check_output({name, "_busy_cycles_s4"}, 32'(busy_cnt4), 32'(exp_busy4));
      check_output({name, "_result_s1"}, result_1, exp_result);
      check_output({name, "_result_s4"}, result_4, exp_result);
      check_output({name, "_zero_s1"}, 32'(zero_1), 32'(exp_zero));
      check_output({name, "_zero_s4"}, 32'(zero_4), 32'(exp_zero));
   endtask

   // Directed sequence followed by randomized operations
   initial begin
      reset = 1'b1; start = 1'b0; flush = 1'b0;
      alu_op = 4'd0; src_a = 32'd0; src_b = 32'd0;
      exp_result = 32'd0; exp_zero = 1'b1;
      repeat (2) @(negedge clk);
      check_output("reset_result_s1", result_1, 32'd0);
      check_output("reset_zero_s1", 32'(zero_1), 32'd1);
      check_output("reset_busy_s1", 32'(busy_1), 32'd0);
      check_output("reset_done_s1", 32'(done_1), 32'd0);
      check_output("reset_result_s4", result_4, 32'd0);
      check_output("reset_busy_s4", 32'(busy_4), 32'd0);
      reset = 1'b0;

      apply_stimulus("add",   4'b0000, 32'h7FFF_FFFF, 32'd1,         0, -1);
      apply_stimulus("sub",   4'b0001, 32'd5,         32'd7,         0, -1);
      apply_stimulus("slt",   4'b0101, 32'hFFFF_FFFF, 32'd1,         0, -1);
      apply_stimulus("sltu",  4'b0110, 32'hFFFF_FFFF, 32'd1,         0, -1);
      apply_stimulus("clr",   4'b1010, 32'h0000_F0F0, 32'h0000_00F0, 0, -1);
      apply_stimulus("pass",  4'b1111, 32'h0000_F0F0, 32'h0000_00F0, 0, -1);
      apply_stimulus("op12",  4'b1100, 32'h1234_5678, 32'h9ABC_DEF0, 0, -1);
      apply_stimulus("sra4",  4'b1001, 32'h8000_0000, 32'd4,         0, -1);
      apply_stimulus("sll0",  4'b0111, 32'hDEAD_BEEF, 32'h0000_0020, 0, -1);
      apply_stimulus("srl31", 4'b1000, 32'hFFFF_FFFF, 32'd31,        0, -1);
      apply_stimulus("sll31", 4'b0111, 32'h0000_0003, 32'd31,        0, -1);
      apply_stimulus("busy_start", 4'b1000, 32'hFFFF_0000, 32'd8,    2, -1);
      apply_stimulus("flush_shift", 4'b1000, 32'h1234_5678, 32'd10,  0,  2);
      apply_stimulus("flush_start", 4'b0000, 32'd1,         32'd1,   0,  0);

      // Asynchronous reset in the middle of a shift
      @(negedge clk);
      alu_op = 4'b0111; src_a = 32'd1; src_b = 32'd20; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check_output("pre_reset_busy_s1", 32'(busy_1), 32'd1);
      check_output("pre_reset_busy_s4", 32'(busy_4), 32'd1);
      #2 reset = 1'b1;
      #1;
      check_output("async_reset_result_s1", result_1, 32'd0);
      check_output("async_reset_zero_s1", 32'(zero_1), 32'd1);
      check_output("async_reset_busy_s1", 32'(busy_1), 32'd0);
      check_output("async_reset_result_s4", result_4, 32'd0);
      check_output("async_reset_zero_s4", 32'(zero_4), 32'd1);
      check_output("async_reset_busy_s4", 32'(busy_4), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      exp_result = 32'd0; exp_zero = 1'b1;
      apply_stimulus("after_reset", 4'b0000, 32'd40, 32'd2, 0, -1);

      for (int i = 0; i < 24; i++) begin
         apply_stimulus($sformatf("rand%0d", i), 4'($urandom_range(15, 0)), $urandom, $urandom, 0, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_iterative.md
Name: alu_iterative

Overview:
- Execute-stage ALU that consumes the 4-bit alu_op code produced by the decode-side ALU control logic and returns a registered result with a start/done handshake.
- Logic, arithmetic and compare ops complete in one cycle.
- Shifts (sll/srl/sra) run iteratively, SHIFT_STEP bit positions per cycle, to keep the barrel shifter off the critical path.
- The pipeline stalls on busy.

Parameters:
- XLEN, 32, datapath width; shift amount is b[4:0] when XLEN=32.
- SHIFT_STEP, 1, maximum bit positions shifted per cycle; must be a power of two from 1 to 16.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- flush  input  1  synchronous abort of any operation in progress
- alu_op  input  4  operation code, encoding below
- src_a  input  XLEN  operand A (rs1/pc; CSR old value for CSR ops)
- src_b  input  XLEN  operand B (rs2/imm; rs1/zimm for CSR ops)
- result  output  XLEN  registered result, held until the next done
- zero  output  1  registered (result == 0), updated together with result
- busy  output  1  high while state != IDLE
- done  output  1  one-cycle pulse when result/zero are updated

Behaviour:
- Reset: asynchronous. state=IDLE; result=0; zero=1; busy=0; done=0; internal accumulator and counter cleared.
- Encoding:
  - 0000 add a+b
  - 0001 sub a-b
  - 0010 and
  - 0011 or
  - 0100 xor
  - 0101 slt (signed) -> {31'b0, a<b}
  - 0110 sltu (unsigned)
  - 0111 sll
  - 1000 srl
  - 1001 sra
  - 1010 a & ~b (csr clear)
  - 1111 pass b (csrrw)
  - 1011-1110: result 0.
- All arithmetic is modulo 2^XLEN; carries and overflow are discarded.
- Operand capture: alu_op, src_a, src_b are latched on the accepting edge. Later input changes have no effect on the operation in progress.
- States:
  - IDLE
  - SHIFT
- IDLE + start, non-shift op, or shift with shamt==0: result/zero registered on that edge; done=1 for the next cycle; remain in IDLE. Latency is 1 cycle. Back-to-back starts are accepted every cycle.
- IDLE + start, shift with shamt>0: load acc=src_a and rem=shamt, then go to SHIFT. done stays 0.
- SHIFT: each edge shifts acc by min(SHIFT_STEP, rem) and decrements rem by the same amount.
  - Logical shifts fill with zeros; sra fills with the sign bit of the original a.
  - On the edge where rem reaches 0: result=acc shifted, done=1 next cycle, return to IDLE.
  - Total latency = 1 + ceil(shamt/SHIFT_STEP) cycles.
- start while busy: ignored and not queued. Upstream holds the request until busy=0.
- flush (any state): on the edge, state=IDLE and done=0 for the next cycle. result/zero keep their previous values.
- flush and start on the same edge: flush wins, and start is dropped.
- done is never high for two consecutive cycles from a single operation.
- busy is low in the cycle done is high for a shift, so a new start may be presented in that cycle.
- Reset mid-SHIFT: immediate return to reset values; no done.

Test Plan:
- add: a=0x7FFFFFFF, b=1, op=0000 -> result=0x80000000, zero=0, done one cycle after start, busy never high. Then sub: a=5, b=7, op=0001 -> 0xFFFFFFFE.
- Compares: a=0xFFFFFFFF, b=1 -> slt (0101) gives 1; sltu (0110) gives 0. CSR ops: a=0xF0F0, b=0x00F0 -> op 1010 gives 0xF000; op 1111 gives 0x00F0. op 1100 -> 0 with zero=1.
- sra with SHIFT_STEP=1: a=0x80000000, b=4 -> busy for 4 cycles, done 5 cycles after start, result=0xF8000000. sll with b=0 -> 1-cycle latency, result=a.
- Shifts with SHIFT_STEP=4: srl a=0xFFFFFFFF, b=31 -> done after 1+8 cycles, result=0x00000001. Repeat with SHIFT_STEP=1 -> done after 32 cycles.
- Second start asserted during busy with different operands -> ignored, and only the first operation's result appears. flush on cycle 2 of a 10-step shift -> no done, busy drops next cycle, result unchanged. flush+start same cycle -> nothing accepted.
- Reset asserted asynchronously mid-shift -> outputs reach reset values (result=0, zero=1, busy=0) before the next clock edge. First start after release behaves normally.
